// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The loader takes the slave side; the stream source / memory take master.
interface instr_mem_loader_if;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_data
    );

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Program loader: assembles big-endian 32-bit words from a byte stream and
// writes them to instruction memory at byte addresses 0, 4, 8, ... while
// holding the CPU stalled. All outputs are registered.
module instr_mem_loader #(
    parameter int unsigned WORD_NUM = 1024,
    parameter int unsigned CNT_W    = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     len_i,
    instr_mem_loader_if.slave    bus,
    output logic                 cpu_hold_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [23:0]        shift_q, shift_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               byte_ready_q, byte_ready_d;
    logic               we_q, we_d;
    logic               hold_q, hold_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               start_ok;
    logic               xfer;

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = 1'b0;

        start_ok = (len_i != '0) && (len_i <= CNT_W'(WORD_NUM));
        xfer     = bus.byte_valid && byte_ready_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    if (start_ok) begin
                        len_d      = len_i;
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                        state_d    = StRecv;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRecv: begin
                if (xfer) begin
                    shift_d    = {shift_q[15:0], bus.byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Fourth byte completes the word; present it with its address.
                        data_d     = {shift_q, bus.byte_data};
                        addr_d     = 32'({word_idx_q, 2'b00});
                        byte_cnt_d = '0;
                        state_d    = StWrite;
                    end
                end
            end
            StWrite: begin
                if (word_idx_q == len_q - CNT_W'(1)) begin
                    state_d = StDone;
                end else begin
                    word_idx_d = word_idx_q + CNT_W'(1);
                    state_d    = StRecv;
                end
            end
        endcase

        byte_ready_d = (state_d == StRecv);
        we_d         = (state_d == StWrite);
        hold_d       = (state_d == StRecv) || (state_d == StWrite);
        busy_d       = hold_d;
        done_d       = (state_d == StDone);
    end

    // State and output registers; async reset clears every output at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            hold_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            byte_ready_q <= byte_ready_d;
            we_q         <= we_d;
            hold_q       <= hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_data   = data_q;
    assign cpu_hold_o     = hold_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: random byte streams, expected writes derived
// from the byte list (word w = bytes 4w..4w+3, big-endian, address 4w).
module tb_instr_mem_loader;
    localparam int WORD_NUM = 1024;
    localparam int CNT_W    = 11;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len   = '0;
    logic             cpu_hold, busy, done, err;

    instr_mem_loader_if bus ();

    always #5 clk = ~clk;

    instr_mem_loader #(
        .WORD_NUM (WORD_NUM),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .start_i    (start),
        .len_i      (len),
        .bus        (bus.slave),
        .cpu_hold_o (cpu_hold),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0]  stream[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {31'd0, bus.byte_ready}, 0);
        check({tag, "_we"},    {31'd0, bus.mem_we}, 0);
        check({tag, "_addr"},  bus.mem_addr, 0);
        check({tag, "_data"},  bus.mem_data, 0);
        check({tag, "_hold"},  {31'd0, cpu_hold}, 0);
        check({tag, "_busy"},  {31'd0, busy}, 0);
        check({tag, "_done"},  {31'd0, done}, 0);
        check({tag, "_err"},   {31'd0, err}, 0);
    endtask

    // Per-cycle compare of memory writes against the expected-write queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we) begin
                log_addr.push_back(bus.mem_addr);
                log_data.push_back(bus.mem_data);
                if (exp_addr.size() == 0) begin
                    check("unexpected_write_addr", bus.mem_addr, 32'hFFFF_FFFF);
                end else begin
                    check("write_addr", bus.mem_addr, exp_addr.pop_front());
                    check("write_data", bus.mem_data, exp_data.pop_front());
                end
            end
            if (err) err_cnt++;
            check("ready_during_write", {31'd0, bus.byte_ready & bus.mem_we}, 0);
            check("hold_vs_busy", {31'd0, cpu_hold}, {31'd0, busy});
            check("hold_while_done", {31'd0, done & cpu_hold}, 0);
        end
    end

    // mode: 0 = valid always, 1 = valid every other cycle, 2 = random bubbles.
    // abort_after > 0 stops streaming after that many accepted bytes.
    task automatic load(input int n, input int mode, input int abort_after,
                        input bit poke_start, input bit use_given, output int cyc);
        int idx;
        bit v, hold, xfer;
        if (!use_given) begin
            stream.delete();
            for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom_range(255)));
        end
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(32'(4 * w));
            exp_data.push_back({stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]});
        end
        log_addr.delete();
        log_data.delete();
        start = 1'b1;
        len   = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        check("ready_after_start", {31'd0, bus.byte_ready}, 1);
        check("hold_after_start", {31'd0, cpu_hold}, 1);
        idx = 0; hold = 1'b0; cyc = 0; v = 1'b0;
        while (!done && cyc < 20 * n + 50 && !(abort_after > 0 && idx >= abort_after)) begin
            if (!hold) begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2 == 0);
                    default: v = ($urandom_range(99) >= 40);
                endcase
                if (idx >= stream.size()) v = 1'b0;
            end
            bus.byte_valid = v;
            bus.byte_data  = v ? stream[idx] : 8'($urandom_range(255));
            if (poke_start && cyc == 2) begin
                start = 1'b1;
                len   = CNT_W'(1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            xfer = v && bus.byte_ready;
            @(posedge clk); #1;
            if (xfer) idx++;
            hold = v && !xfer;
            cyc++;
        end
        bus.byte_valid = 1'b0;
        start = 1'b0;
        if (abort_after == 0) check("load_reached_done", {31'd0, done}, 1);
    endtask

    task automatic reject(input int n, input bit exp_done);
        start = 1'b1;
        len   = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        check("reject_err_pulse", {31'd0, err}, 1);
        check("reject_busy", {31'd0, busy}, 0);
        check("reject_hold", {31'd0, cpu_hold}, 0);
        check("reject_done_kept", {31'd0, done}, {31'd0, exp_done});
        @(posedge clk); #1;
        check("reject_err_one_cycle", {31'd0, err}, 0);
        check("reject_ready", {31'd0, bus.byte_ready}, 0);
        check("reject_busy2", {31'd0, busy}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int e0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fixed program: two MIPS words, back-to-back bytes.
        stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        load(2, 0, 0, 1'b0, 1'b1, cyc);
        check("fixed_cycles", 32'(cyc), 10);
        check("fixed_write_count", 32'(log_addr.size()), 2);
        if (log_addr.size() == 2) begin
            check("fixed_addr0", log_addr[0], 32'h0);
            check("fixed_data0", log_data[0], 32'h2008_0005);
            check("fixed_addr1", log_addr[1], 32'h4);
            check("fixed_data1", log_data[1], 32'h8C09_0004);
        end
        check("fixed_hold_done", {31'd0, cpu_hold}, 0);
        check("fixed_queue_empty", 32'(exp_addr.size()), 0);

        // One word, valid toggling.
        load(1, 1, 0, 1'b0, 1'b0, cyc);
        check("toggle_write_count", 32'(log_addr.size()), 1);
        check("toggle_queue_empty", 32'(exp_addr.size()), 0);

        // Rejects from DONE keep done high.
        reject(0, 1'b1);
        reject(1025, 1'b1);

        // Start poked mid-RECV must be ignored.
        e0 = err_cnt;
        load(3, 2, 0, 1'b1, 1'b0, cyc);
        check("poke_write_count", 32'(log_addr.size()), 3);
        if (log_addr.size() == 3) check("poke_last_addr", log_addr[2], 32'h8);
        check("poke_no_err", 32'(err_cnt - e0), 0);
        check("poke_queue_empty", 32'(exp_addr.size()), 0);

        // Reset after 6 bytes of a 2-word load.
        load(2, 0, 6, 1'b0, 1'b0, cyc);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        check("midreset_writes", 32'(log_addr.size()), 1);
        exp_addr.delete();
        exp_data.delete();
        @(posedge clk); #1 rst_n = 1'b1;

        // Rejects from IDLE leave it idle.
        reject(0, 1'b0);
        reject(1025, 1'b0);

        load(1, 2, 0, 1'b0, 1'b0, cyc);
        check("post_reset_count", 32'(log_addr.size()), 1);
        if (log_addr.size() == 1) check("post_reset_addr", log_addr[0], 32'h0);
        check("post_reset_queue", 32'(exp_addr.size()), 0);

        // Full-depth load.
        load(1024, 0, 0, 1'b0, 1'b0, cyc);
        check("full_cycles", 32'(cyc), 5120);
        check("full_write_count", 32'(log_addr.size()), 1024);
        if (log_addr.size() == 1024) check("full_last_addr", log_addr[1023], 32'hFFC);
        check("full_done", {31'd0, done}, 1);
        check("full_hold", {31'd0, cpu_hold}, 0);
        check("full_queue_empty", 32'(exp_addr.size()), 0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
